// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the fetch stage and later stages.
package mips_pkg;

    localparam int XLEN       = 32;
    localparam int JUMP_IDX_W = 26;

    typedef logic [XLEN-1:0] pc_t;

    localparam pc_t NOP_WORD         = 32'h0000_0000;
    localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;

    // j/jal target: region bits come from the PC+4 of the jump itself.
    function automatic pc_t jump_target(input pc_t pc_plus4, input logic [JUMP_IDX_W-1:0] idx);
        return {pc_plus4[XLEN-1:XLEN-4], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory and IF/ID outputs.
interface fetch_stage_if;
    import mips_pkg::*;

    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  pc_src_d;
    pc_t                   branch_target_d;
    logic                  jump_d;
    logic [JUMP_IDX_W-1:0] jump_index_d;
    pc_t                   imem_addr;
    pc_t                   imem_rdata;
    pc_t                   instr_d;
    pc_t                   pc_plus4_d;
    logic                  valid_d;

    modport master (
        input  stall_f, stall_d, flush_d, pc_src_d, branch_target_d,
        input  jump_d, jump_index_d, imem_rdata,
        output imem_addr, instr_d, pc_plus4_d, valid_d
    );

    modport slave (
        output stall_f, stall_d, flush_d, pc_src_d, branch_target_d,
        output jump_d, jump_index_d, imem_rdata,
        input  imem_addr, instr_d, pc_plus4_d, valid_d
    );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: sync reset, hold when en=0, sync clear to CLR_VAL (clear beats hold).
module pipe_reg_en_clr #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC selection and the IF/ID pipeline register.
module fetch_stage
    import mips_pkg::pc_t;
    import mips_pkg::XLEN;
    import mips_pkg::RESET_PC_DEFAULT;
    import mips_pkg::jump_target;
#(
    parameter pc_t RESET_PC = RESET_PC_DEFAULT,
    parameter pc_t NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam int IFID_W = 1 + 2 * XLEN;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, {XLEN{1'b0}}, NOP_WORD};

    pc_t               pc_f;
    pc_t               pc_plus4_f;
    pc_t               pc_next_f;
    pc_t               pc_plus4_d;
    logic [IFID_W-1:0] ifid_in;
    logic [IFID_W-1:0] ifid_q;

    // ---- IF: PC and next-PC selection (jump beats branch) ----
    assign pc_plus4_f = pc_f + 32'd4;

    always_comb begin
        pc_next_f = pc_plus4_f;
        if (bus.jump_d) begin
            pc_next_f = jump_target(pc_plus4_d, bus.jump_index_d);
        end else if (bus.pc_src_d) begin
            pc_next_f = bus.branch_target_d;
        end
    end

    pipe_reg_en_clr #(
        .DATA_W  (XLEN),
        .RST_VAL (RESET_PC),
        .CLR_VAL ('0)
    ) u_pc_reg (
        .clk (clk),
        .rst (reset),
        .en  (~bus.stall_f),
        .clr (1'b0),
        .d   (pc_next_f),
        .q   (pc_f)
    );

    assign bus.imem_addr = pc_f;

    // ---- IF/ID boundary: {valid, pc_plus4, instr}; flush beats stall ----
    assign ifid_in = {1'b1, pc_plus4_f, bus.imem_rdata};

    pipe_reg_en_clr #(
        .DATA_W  (IFID_W),
        .RST_VAL (IFID_BUBBLE),
        .CLR_VAL (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk (clk),
        .rst (reset),
        .en  (~bus.stall_d),
        .clr (bus.flush_d),
        .d   (ifid_in),
        .q   (ifid_q)
    );

    assign bus.valid_d    = ifid_q[IFID_W-1];
    assign pc_plus4_d     = ifid_q[2*XLEN-1:XLEN];
    assign bus.pc_plus4_d = pc_plus4_d;
    assign bus.instr_d    = ifid_q[XLEN-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized redirects/stalls against a behavioural model.
module tb_fetch_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural view of the stage's architectural state.
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset               = 1'b0;
        bus.stall_f         = 1'b0;
        bus.stall_d         = 1'b0;
        bus.flush_d         = 1'b0;
        bus.pc_src_d        = 1'b0;
        bus.branch_target_d = 32'h0;
        bus.jump_d          = 1'b0;
        bus.jump_index_d    = 26'h0;
    endtask

    // Advance one clock: compute what the stage must hold afterwards, then compare.
    task automatic step();
        logic [31:0] n_pc, n_instr, n_pp4;
        logic        n_valid;
        n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid;
        if (reset) begin
            n_pc = 32'h0; n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0;
        end else begin
            if (!bus.stall_f) begin
                if (bus.jump_d)
                    n_pc = (m_pp4 & 32'hF000_0000) + ({6'b0, bus.jump_index_d} * 4);
                else if (bus.pc_src_d)
                    n_pc = bus.branch_target_d;
                else
                    n_pc = m_pc + 4;
            end
            if (bus.flush_d) begin
                n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0;
            end else if (!bus.stall_d) begin
                n_instr = mem_word(m_pc); n_pp4 = m_pc + 4; n_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
        chk("imem_addr",  bus.imem_addr,  m_pc);
        chk("instr_d",    bus.instr_d,    m_instr);
        chk("pc_plus4_d", bus.pc_plus4_d, m_pp4);
        chk("valid_d",    {31'b0, bus.valid_d}, {31'b0, m_valid});
    endtask

    initial begin
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        chk("rst_pc",    bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.valid_d}, 32'h0);

        // Sequential fetch.
        reset = 1'b0;
        repeat (2) step();
        chk("seq_addr8",  bus.imem_addr,  32'h8);
        chk("seq_instr4", bus.instr_d,    32'h1000_0004);
        chk("seq_pp4",    bus.pc_plus4_d, 32'h8);

        // Stall both stages at pc=8, then release.
        bus.stall_f = 1'b1; bus.stall_d = 1'b1;
        repeat (2) step();
        chk("stall_addr", bus.imem_addr, 32'h8);
        bus.stall_f = 1'b0; bus.stall_d = 1'b0;
        step();
        chk("stall_rel_instr", bus.instr_d, 32'h1000_0008);
        step();
        chk("stall_rel_instr12", bus.instr_d, 32'h1000_000C);

        // Taken branch with flush at pc=0x10.
        chk("pre_branch_pc", bus.imem_addr, 32'h10);
        bus.pc_src_d = 1'b1; bus.branch_target_d = 32'h40; bus.flush_d = 1'b1;
        step();
        chk("br_addr", bus.imem_addr, 32'h40);
        idle_inputs();
        step();
        chk("br_instr", bus.instr_d,    32'h1000_0040);
        chk("br_pp4",   bus.pc_plus4_d, 32'h44);

        // Jump and branch together; region from decode-stage PC+4.
        bus.pc_src_d = 1'b1; bus.branch_target_d = 32'h3000_0004;
        step();
        idle_inputs();
        step();
        chk("jmp_pp4_d", bus.pc_plus4_d, 32'h3000_0008);
        bus.jump_d = 1'b1; bus.jump_index_d = 26'h0000100;
        bus.pc_src_d = 1'b1; bus.branch_target_d = 32'h80;
        step();
        chk("jmp_wins", bus.imem_addr, 32'h3000_0400);
        idle_inputs();

        // Flush and stall together give a bubble.
        bus.flush_d = 1'b1; bus.stall_d = 1'b1;
        step();
        chk("flush_stall_valid", {31'b0, bus.valid_d}, 32'h0);
        idle_inputs();
        step();

        // Reset during a stall.
        bus.stall_f = 1'b1; bus.stall_d = 1'b1; reset = 1'b1;
        step();
        chk("rst_stall_pc",    bus.imem_addr, 32'h0);
        chk("rst_stall_instr", bus.instr_d,   32'h0);
        idle_inputs();
        step();

        // PC wrap-around.
        bus.pc_src_d = 1'b1; bus.branch_target_d = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        chk("wrap_addr",  bus.imem_addr,  32'h0);
        chk("wrap_pp4",   bus.pc_plus4_d, 32'h0);
        chk("wrap_instr", bus.instr_d,    32'hFFFF_FFFC);

        // Randomized traffic, including unaligned targets and near-top PCs.
        for (int i = 0; i < 400; i++) begin
            reset               = ($urandom_range(0, 63) == 0);
            bus.stall_f         = ($urandom_range(0, 7) == 0);
            bus.stall_d         = ($urandom_range(0, 7) == 0);
            bus.flush_d         = ($urandom_range(0, 7) == 0);
            bus.pc_src_d        = ($urandom_range(0, 5) == 0);
            bus.jump_d          = ($urandom_range(0, 9) == 0);
            bus.branch_target_d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                              : 32'($urandom);
            bus.jump_index_d    = 26'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
